// File: rtl/note_glide.sv
// Portamento pitch slewer: tracks a clamped note target in fixed-point pitch
// steps, stepping one LSB every glide_rate enable strobes.
module note_glide #(
  parameter int FRAC_BITS = 6,
  parameter int MAX_NOTE  = 59
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   note_valid,
  input  logic [6:0]             note_num,
  input  logic [7:0]             glide_rate,
  output logic [6+FRAC_BITS-1:0] pitch_out,
  output logic                   gliding,
  output logic                   done
);

  localparam int PW = 6 + FRAC_BITS;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GLIDE = 1'b1;

  logic [0:0]    state_reg, state_next;
  logic [PW-1:0] target_reg, target_next;
  logic [PW-1:0] pitch_reg, pitch_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic          gliding_reg;
  logic          done_reg, done_next;

  logic [5:0]    clamped;
  logic [PW-1:0] new_target;
  logic          step_due;

  assign clamped    = (note_num > 7'(MAX_NOTE)) ? 6'(MAX_NOTE) : note_num[5:0];
  assign new_target = {clamped, {FRAC_BITS{1'b0}}};
  // Widened compare so a counter of 255 cannot wrap past glide_rate
  assign step_due   = enable && (({1'b0, cnt_reg} + 9'd1) >= {1'b0, glide_rate});

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    pitch_next  = pitch_reg;
    cnt_next    = cnt_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (note_valid) begin
          target_next = new_target;
          if (new_target != pitch_reg) begin
            if (glide_rate == 8'd0) begin
              pitch_next = new_target;
              done_next  = 1'b1;
            end else begin
              state_next = GLIDE;
              cnt_next   = 8'd0;
            end
          end
        end
      end
      GLIDE: begin
        if (note_valid) begin
          // Retarget wins over a coincident step; the step's counter clear still applies
          target_next = new_target;
          if (step_due) cnt_next = 8'd0;
          if (new_target == pitch_reg) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (glide_rate == 8'd0) begin
            pitch_next = new_target;
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else if (pitch_reg == target_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (enable) begin
          if (step_due) begin
            cnt_next = 8'd0;
            if (pitch_reg < target_reg) pitch_next = pitch_reg + 1'b1;
            else                        pitch_next = pitch_reg - 1'b1;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      target_reg  <= '0;
      pitch_reg   <= '0;
      cnt_reg     <= '0;
      gliding_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      target_reg  <= target_next;
      pitch_reg   <= pitch_next;
      cnt_reg     <= cnt_next;
      gliding_reg <= (state_next == GLIDE);
      done_reg    <= done_next;
    end
  end

  assign pitch_out = pitch_reg;
  assign gliding   = gliding_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_note_glide.sv
// Directed bench for note_glide: jumps, glides, reversal, retarget priority
// and asynchronous reset, with hand-computed expected pitches.
module tb_note_glide;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        note_valid;
  logic [6:0]  note_num;
  logic [7:0]  glide_rate;
  logic [11:0] pitch_out;
  logic        gliding;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  note_glide #(.FRAC_BITS(6), .MAX_NOTE(59)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .note_valid (note_valid),
    .note_num   (note_num),
    .glide_rate (glide_rate),
    .pitch_out  (pitch_out),
    .gliding    (gliding),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; note_valid = 1'b0; note_num = '0; glide_rate = '0;
    #2;
    chk("rst_pitch", 32'(pitch_out), 0);
    chk("rst_gliding", 32'(gliding), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk); #3; reset_n = 1'b1;

    // Note 12 with no glide, accepted on the first edge after reset
    note_valid = 1'b1; note_num = 7'd12; glide_rate = 8'd0;
    tick(); note_valid = 1'b0;
    chk("jump12_pitch", 32'(pitch_out), 768);
    chk("jump12_done", 32'(done), 1);
    chk("jump12_gliding", 32'(gliding), 0);
    tick();
    chk("jump12_done_clear", 32'(done), 0);
    chk("jump12_hold", 32'(pitch_out), 768);

    // Out-of-range note clamps to 59
    note_valid = 1'b1; note_num = 7'd100;
    tick(); note_valid = 1'b0;
    chk("clamp_pitch", 32'(pitch_out), 3776);
    chk("clamp_done", 32'(done), 1);

    note_valid = 1'b1; note_num = 7'd0;
    tick(); note_valid = 1'b0;
    chk("back_to_zero", 32'(pitch_out), 0);

    // Glide 0 -> 128 at 4 enables per LSB
    note_valid = 1'b1; note_num = 7'd2; glide_rate = 8'd4;
    tick(); note_valid = 1'b0;
    chk("glide_start_gliding", 32'(gliding), 1);
    chk("glide_start_pitch", 32'(pitch_out), 0);
    enable = 1'b1;
    for (int i = 1; i <= 512; i++) begin
      tick();
      chk("glide_up_pitch", 32'(pitch_out), 32'(i / 4));
    end
    chk("glide_up_still_gliding", 32'(gliding), 1);
    chk("glide_up_no_early_done", 32'(done), 0);
    enable = 1'b0;
    tick();
    chk("glide_up_done", 32'(done), 1);
    chk("glide_up_end_gliding", 32'(gliding), 0);
    chk("glide_up_end_pitch", 32'(pitch_out), 128);
    tick();
    chk("glide_up_done_once", 32'(done), 0);

    // Reverse mid-glide at pitch 50 toward 0
    note_valid = 1'b1; note_num = 7'd0; glide_rate = 8'd0;
    tick(); note_valid = 1'b0;
    chk("rev_setup_pitch", 32'(pitch_out), 0);
    note_valid = 1'b1; note_num = 7'd1; glide_rate = 8'd1;
    tick(); note_valid = 1'b0;
    enable = 1'b1;
    repeat (50) tick();
    chk("rev_at50", 32'(pitch_out), 50);
    enable = 1'b0; note_valid = 1'b1; note_num = 7'd0;
    tick(); note_valid = 1'b0;
    chk("rev_retarget_pitch", 32'(pitch_out), 50);
    chk("rev_retarget_gliding", 32'(gliding), 1);
    enable = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      chk("rev_down_pitch", 32'(pitch_out), 32'(50 - i));
      chk("rev_down_no_done", 32'(done), 0);
    end
    enable = 1'b0;
    tick();
    chk("rev_done", 32'(done), 1);
    chk("rev_end_gliding", 32'(gliding), 0);
    chk("rev_end_pitch", 32'(pitch_out), 0);

    // note_valid coincident with a step-qualifying enable
    note_valid = 1'b1; note_num = 7'd1; glide_rate = 8'd2;
    tick(); note_valid = 1'b0;
    enable = 1'b1;
    tick();
    chk("coinc_pre", 32'(pitch_out), 0);
    note_valid = 1'b1; note_num = 7'd2;
    tick(); note_valid = 1'b0;
    chk("coinc_suppressed", 32'(pitch_out), 0);
    tick();
    chk("coinc_cnt_cleared", 32'(pitch_out), 0);
    tick();
    chk("coinc_next_step", 32'(pitch_out), 1);

    // Retarget with glide_rate 0 during a glide jumps immediately
    enable = 1'b0; glide_rate = 8'd0; note_valid = 1'b1; note_num = 7'd3;
    tick(); note_valid = 1'b0;
    chk("retarget_jump_pitch", 32'(pitch_out), 192);
    chk("retarget_jump_done", 32'(done), 1);
    chk("retarget_jump_gliding", 32'(gliding), 0);

    // Retarget onto the current pitch ends the glide
    note_valid = 1'b1; note_num = 7'd0; glide_rate = 8'd1;
    tick(); note_valid = 1'b0;
    enable = 1'b1;
    repeat (64) tick();
    enable = 1'b0;
    chk("retarget_eq_setup", 32'(pitch_out), 128);
    note_valid = 1'b1; note_num = 7'd2;
    tick(); note_valid = 1'b0;
    chk("retarget_eq_done", 32'(done), 1);
    chk("retarget_eq_gliding", 32'(gliding), 0);
    chk("retarget_eq_pitch", 32'(pitch_out), 128);
    tick();
    chk("retarget_eq_done_once", 32'(done), 0);

    // Asynchronous reset mid-glide
    note_valid = 1'b1; note_num = 7'd5; glide_rate = 8'd3;
    tick(); note_valid = 1'b0;
    chk("arst_gliding_before", 32'(gliding), 1);
    enable = 1'b1;
    repeat (5) tick();
    chk("arst_pitch_before", 32'(pitch_out), 129);
    #2; reset_n = 1'b0;
    #1;
    chk("arst_pitch", 32'(pitch_out), 0);
    chk("arst_gliding", 32'(gliding), 0);
    chk("arst_done", 32'(done), 0);
    tick();
    chk("arst_hold_done", 32'(done), 0);
    chk("arst_hold_pitch", 32'(pitch_out), 0);
    #3; reset_n = 1'b1; enable = 1'b0;
    note_valid = 1'b1; note_num = 7'd1; glide_rate = 8'd0;
    tick(); note_valid = 1'b0;
    chk("post_rst_first_edge", 32'(pitch_out), 64);
    chk("post_rst_done", 32'(done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
